// File: rtl/i2c_eeprom_slave_if.sv
// I2C slave bit-level front-end: synchronised and filtered SCL/SDA, START/STOP
// detection, address match, ACK generation and byte-wide read/write handshake.
module i2c_eeprom_slave_if #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] byte_o,
  output logic       byte_vld,
  output logic       first_o,
  input  logic [7:0] rd_data_i,
  output logic       rd_req,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

  logic [1:0] scl_sync, sda_sync;
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_fd, sda_fd;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       ack_rise, ack_rise_nx;
  logic       rw, rw_nx;
  logic       first_flag, first_flag_nx;
  logic       oe_nx, vld_nx, first_nx, start_nx, stop_nx, busy_nx;
  logic [7:0] byte_nx;

  // Filtered level only follows the synchronised line after FILTER_LEN
  // consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_fd   <= 1'b1;
      sda_fd   <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_fd   <= scl_f;
      sda_fd   <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FLT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FLT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_fd;
  assign scl_fall  = ~scl_f & scl_fd;
  assign start_det = scl_f & scl_fd & sda_fd & ~sda_f;
  assign stop_det  = scl_f & scl_fd & ~sda_fd & sda_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      ack_rise   <= 1'b0;
      rw         <= 1'b0;
      first_flag <= 1'b0;
      sda_oe     <= 1'b0;
      byte_o     <= '0;
      byte_vld   <= 1'b0;
      first_o    <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      ack_rise   <= ack_rise_nx;
      rw         <= rw_nx;
      first_flag <= first_flag_nx;
      sda_oe     <= oe_nx;
      byte_o     <= byte_nx;
      byte_vld   <= vld_nx;
      first_o    <= first_nx;
      start_o    <= start_nx;
      stop_o     <= stop_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    shreg_nx      = shreg;
    ack_rise_nx   = ack_rise;
    rw_nx         = rw;
    first_flag_nx = first_flag;
    oe_nx         = sda_oe;
    byte_nx       = byte_o;
    busy_nx       = busy;
    vld_nx        = 1'b0;
    first_nx      = 1'b0;
    start_nx      = 1'b0;
    stop_nx       = 1'b0;
    rd_req        = 1'b0;

    if (stop_det) begin
      state_nx = IDLE;
      oe_nx    = 1'b0;
      stop_nx  = 1'b1;
      busy_nx  = 1'b0;
    end else if (start_det) begin
      state_nx = ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
      start_nx = 1'b1;
      busy_nx  = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shreg_nx = {shreg[6:0], sda_f};
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (shreg[6:0] == DEV_ADDR) begin
              state_nx    = ADDR_ACK;
              rw_nx       = sda_f;
              ack_rise_nx = 1'b0;
            end else begin
              state_nx = IGNORE;
            end
          end
        end
        // Both ACK states: drive on the first fall, release on the fall that
        // follows the 9th rise; a read address loads the first TX byte there.
        ADDR_ACK, WR_ACK: begin
          if (scl_rise) begin
            ack_rise_nx = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rise) begin
              oe_nx = 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              rd_req   = 1'b1;
              oe_nx    = ~rd_data_i[7];
              shreg_nx = {rd_data_i[6:0], 1'b0};
              cnt_nx   = 3'd1;
              state_nx = RD_BYTE;
            end else begin
              oe_nx    = 1'b0;
              cnt_nx   = '0;
              state_nx = WR_BYTE;
              if (state == ADDR_ACK) first_flag_nx = 1'b1;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg_nx = {shreg[6:0], sda_f};
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            byte_nx       = {shreg[6:0], sda_f};
            vld_nx        = 1'b1;
            first_nx      = first_flag;
            first_flag_nx = 1'b0;
            ack_rise_nx   = 1'b0;
            state_nx      = WR_ACK;
          end
        end
        // cnt counts bits already driven; wrapping to 0 means all 8 are out.
        RD_BYTE: if (scl_fall) begin
          if (cnt == 3'd0) begin
            oe_nx       = 1'b0;
            ack_rise_nx = 1'b0;
            state_nx    = RD_ACK;
          end else begin
            oe_nx    = ~shreg[7];
            shreg_nx = {shreg[6:0], 1'b0};
            cnt_nx   = cnt + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_nx = IGNORE;
            else       ack_rise_nx = 1'b1;
          end else if (scl_fall && ack_rise) begin
            rd_req   = 1'b1;
            oe_nx    = ~rd_data_i[7];
            shreg_nx = {rd_data_i[6:0], 1'b0};
            cnt_nx   = 3'd1;
            state_nx = RD_BYTE;
          end
        end
        IGNORE: oe_nx = 1'b0;
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave_if.sv
// Directed bench for i2c_eeprom_slave_if: a bit-banged I2C master drives the
// slave through write, mismatch, read, random-read, abort and reset scenarios.
module tb_i2c_eeprom_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe;
  logic [7:0] byte_o;
  logic       byte_vld, first_o, rd_req, start_o, stop_o, busy;
  logic [7:0] rd_data_i;
  wire        sda_line = sda_m & ~sda_oe;

  int n_cmp = 0;
  int n_err = 0;

  int n_vld = 0, n_start = 0, n_stop = 0, n_rdreq = 0, n_oe = 0;
  int rd_cnt = 0;
  logic [7:0] byte_log [32];
  logic       first_log [32];
  logic [7:0] rd_tab [16];

  assign rd_data_i = rd_tab[rd_cnt[3:0]];

  i2c_eeprom_slave_if #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .byte_o(byte_o), .byte_vld(byte_vld), .first_o(first_o),
    .rd_data_i(rd_data_i), .rd_req(rd_req), .start_o(start_o),
    .stop_o(stop_o), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_req) rd_cnt <= rd_cnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_vld) begin
        if (n_vld < 32) begin
          byte_log[n_vld]  <= byte_o;
          first_log[n_vld] <= first_o;
        end
        n_vld <= n_vld + 1;
      end
      if (start_o) n_start <= n_start + 1;
      if (stop_o)  n_stop  <= n_stop + 1;
      if (rd_req)  n_rdreq <= n_rdreq + 1;
      if (sda_oe)  n_oe    <= n_oe + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: data set mid-low, line sampled mid-high.
  task automatic xfer_bit(input logic b, output logic s);
    scl = 1'b0; wait_clk(4);
    sda_m = b;  wait_clk(8);
    scl = 1'b1; wait_clk(6);
    s = sda_line; wait_clk(6);
  endtask

  task automatic i2c_start();
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b1; wait_clk(8);
    scl = 1'b1; wait_clk(12);
    sda_m = 1'b0; wait_clk(12);
  endtask

  task automatic i2c_stop();
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b0; wait_clk(8);
    scl = 1'b1; wait_clk(12);
    sda_m = 1'b1; wait_clk(12);
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) xfer_bit(v[7-i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic rbyte(output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wait_clk(4);
    n_cmp++; if (sda_oe !== 1'b0)   begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (byte_o !== 8'h00)  begin n_err++; $display("FAIL reset_byte_o: got %h expected 00", byte_o); end
    n_cmp++; if (byte_vld !== 1'b0) begin n_err++; $display("FAIL reset_byte_vld: got %b expected 0", byte_vld); end
    n_cmp++; if (start_o !== 1'b0 || stop_o !== 1'b0 || rd_req !== 1'b0 || first_o !== 1'b0)
      begin n_err++; $display("FAIL reset_pulses: got %b%b%b%b expected 0000", start_o, stop_o, rd_req, first_o); end
    rst_n = 1'b1; wait_clk(10);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int v0 = n_vld, s0 = n_start, p0 = n_stop;
    i2c_start();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_start: got %b expected 1", busy); end
    wbyte(8'hA0, a0); wbyte(8'h12, a1); wbyte(8'h34, a2);
    i2c_stop(); wait_clk(4);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL wr_acks: got %b expected 000", {a0, a1, a2}); end
    n_cmp++; if (n_vld - v0 != 2) begin n_err++; $display("FAIL wr_vld_count: got %0d expected 2", n_vld - v0); end
    n_cmp++; if (byte_log[v0] !== 8'h12 || first_log[v0] !== 1'b1)
      begin n_err++; $display("FAIL wr_byte0: got %h/%b expected 12/1", byte_log[v0], first_log[v0]); end
    n_cmp++; if (byte_log[v0+1] !== 8'h34 || first_log[v0+1] !== 1'b0)
      begin n_err++; $display("FAIL wr_byte1: got %h/%b expected 34/0", byte_log[v0+1], first_log[v0+1]); end
    n_cmp++; if (n_start - s0 != 1 || n_stop - p0 != 1)
      begin n_err++; $display("FAIL wr_start_stop: got %0d/%0d expected 1/1", n_start - s0, n_stop - p0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
    n_cmp++; if (byte_o !== 8'h34) begin n_err++; $display("FAIL wr_byte_hold: got %h expected 34", byte_o); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int v0 = n_vld, p0 = n_stop, o0 = n_oe;
    i2c_start();
    wbyte(8'hA2, a0); wbyte(8'h55, a1);
    i2c_stop(); wait_clk(4);
    n_cmp++; if ({a0, a1} !== 2'b11) begin n_err++; $display("FAIL mm_nack: got %b expected 11", {a0, a1}); end
    n_cmp++; if (n_oe != o0) begin n_err++; $display("FAIL mm_oe_cycles: got %0d expected %0d", n_oe, o0); end
    n_cmp++; if (n_vld != v0) begin n_err++; $display("FAIL mm_vld: got %0d expected %0d", n_vld, v0); end
    n_cmp++; if (n_stop - p0 != 1) begin n_err++; $display("FAIL mm_stop: got %0d expected 1", n_stop - p0); end
  endtask

  task automatic test_read();
    logic a0, s;
    logic [7:0] d0, d1, d2;
    int r0 = n_rdreq;
    i2c_start();
    wbyte(8'hA1, a0);
    rbyte(d0); xfer_bit(1'b0, s);
    rbyte(d1); xfer_bit(1'b0, s);
    rbyte(d2); xfer_bit(1'b1, s);
    wait_clk(4);
    n_cmp++; if (sda_oe !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL rd_after_nack: got oe=%b busy=%b expected oe=0 busy=1", sda_oe, busy); end
    i2c_stop(); wait_clk(4);
    n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b expected 0", a0); end
    n_cmp++; if (d0 !== 8'h5A) begin n_err++; $display("FAIL rd_byte0: got %h expected 5a", d0); end
    n_cmp++; if (d1 !== 8'hC3) begin n_err++; $display("FAIL rd_byte1: got %h expected c3", d1); end
    n_cmp++; if (d2 !== 8'h0F) begin n_err++; $display("FAIL rd_byte2: got %h expected 0f", d2); end
    n_cmp++; if (n_rdreq - r0 != 3) begin n_err++; $display("FAIL rd_req_count: got %0d expected 3", n_rdreq - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %b expected 0", busy); end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, s;
    logic [7:0] d;
    int v0 = n_vld, s0 = n_start, r0 = n_rdreq;
    i2c_start();
    wbyte(8'hA0, a0); wbyte(8'h07, a1);
    i2c_start();
    wbyte(8'hA1, a2);
    rbyte(d); xfer_bit(1'b1, s);
    i2c_stop(); wait_clk(4);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rr_acks: got %b expected 000", {a0, a1, a2}); end
    n_cmp++; if (n_vld - v0 != 1 || byte_log[v0] !== 8'h07 || first_log[v0] !== 1'b1)
      begin n_err++; $display("FAIL rr_word_addr: got n=%0d %h/%b expected n=1 07/1", n_vld - v0, byte_log[v0], first_log[v0]); end
    n_cmp++; if (n_start - s0 != 2) begin n_err++; $display("FAIL rr_start_count: got %0d expected 2", n_start - s0); end
    n_cmp++; if (n_rdreq - r0 != 1) begin n_err++; $display("FAIL rr_req_count: got %0d expected 1", n_rdreq - r0); end
    n_cmp++; if (d !== 8'h96) begin n_err++; $display("FAIL rr_data: got %h expected 96", d); end
  endtask

  task automatic test_abort();
    logic a0, a1, s;
    int v0 = n_vld;
    i2c_start();
    wbyte(8'hA0, a0);
    xfer_bit(1'b1, s); xfer_bit(1'b0, s); xfer_bit(1'b1, s); xfer_bit(1'b0, s);
    i2c_stop();
    i2c_start();
    wbyte(8'hA0, a1);
    i2c_stop(); wait_clk(4);
    n_cmp++; if (n_vld != v0) begin n_err++; $display("FAIL ab_partial_vld: got %0d expected %0d", n_vld, v0); end
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_err++; $display("FAIL ab_addr_ack: got %b expected 00", {a0, a1}); end
  endtask

  task automatic test_reset_mid_ack();
    logic s, a0, a1;
    int v0;
    i2c_start();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] addr = 8'hA0;
      xfer_bit(addr[7-i], s);
    end
    scl = 1'b0; wait_clk(4);
    sda_m = 1'b1; wait_clk(8);
    n_cmp++; if (sda_oe !== 1'b1 || busy !== 1'b1)
      begin n_err++; $display("FAIL rst_pre_ack: got oe=%b busy=%b expected 1/1", sda_oe, busy); end
    rst_n = 1'b0; wait_clk(1);
    rst_n = 1'b1;
    n_cmp++; if (sda_oe !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_ack: got oe=%b busy=%b expected 0/0", sda_oe, busy); end
    wait_clk(12);
    scl = 1'b1; wait_clk(12);
    v0 = n_vld;
    i2c_start();
    wbyte(8'hA0, a0); wbyte(8'h5C, a1);
    i2c_stop(); wait_clk(4);
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_err++; $display("FAIL rst_resume_ack: got %b expected 00", {a0, a1}); end
    n_cmp++; if (n_vld - v0 != 1 || byte_log[v0] !== 8'h5C || first_log[v0] !== 1'b1)
      begin n_err++; $display("FAIL rst_resume_byte: got n=%0d %h/%b expected n=1 5c/1", n_vld - v0, byte_log[v0], first_log[v0]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rd_tab[i] = 8'hEE;
    rd_tab[0] = 8'h5A; rd_tab[1] = 8'hC3; rd_tab[2] = 8'h0F; rd_tab[3] = 8'h96;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_random_read();
    test_abort();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
